// File: rtl/round_judge.sv
// round_judge: five-probe ball safety judge with round timer; define ROUND_JUDGE_GRACE_EN for a start-of-round miss grace window.
module round_judge #(
    parameter int SCREEN_WIDTH  = 400,
    parameter int SCREEN_HEIGHT = 600,
    parameter int BALL_RADIUS   = 10,
    parameter int ROUND_FRAMES  = 600,
    parameter int MISS_LIMIT    = 3,
    parameter int SAFE_LATENCY  = 1,
    parameter int GRACE_FRAMES  = 30
) (
    input  logic                              clk,
    input  logic                              arst,
    input  logic                              i_round_start,
    input  logic                              i_pause,
    input  logic                              i_frame_start,
    input  logic [$clog2(SCREEN_WIDTH)-1:0]   i_x,
    input  logic [$clog2(SCREEN_HEIGHT)-1:0]  i_y,
    input  logic                              i_is_safe,
    input  logic [$clog2(SCREEN_WIDTH)-1:0]   i_ball_x,
    input  logic [$clog2(SCREEN_HEIGHT)-1:0]  i_ball_y,
    output logic                              o_round_ended,
    output logic                              o_is_win,
    output logic [$clog2(ROUND_FRAMES+1)-1:0] o_time_left,
    output logic [$clog2(MISS_LIMIT+1)-1:0]   o_miss_cnt
);
    localparam int XW = $clog2(SCREEN_WIDTH);
    localparam int YW = $clog2(SCREEN_HEIGHT);
    localparam int TW = $clog2(ROUND_FRAMES+1);
    localparam int MW = $clog2(MISS_LIMIT+1);

    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_t;
    state_t state, state_nxt;

    logic [XW-1:0] bx;
    logic [YW-1:0] by;
    logic [4:0] flags, hit;
    logic [4:0][XW-1:0] px;
    logic [4:0][YW-1:0] py;
    logic [SAFE_LATENCY-1:0][XW-1:0] dx;
    logic [SAFE_LATENCY-1:0][YW-1:0] dy;
    logic first, run, fs_run, eval, in_grace, miss_any, lose, win_now;
    logic [TW-1:0] time_nxt;
    logic [MW-1:0] miss_nxt;

    assign run    = state == RUNNING && !i_pause && !i_round_start;
    assign fs_run = run && i_frame_start;
    assign eval   = fs_run && !first;

    // Probes: centre, left, right, up, down, clamped to the screen
    always_comb begin
        px = {5{bx}};
        py = {5{by}};
        px[1] = int'(bx) < BALL_RADIUS ? '0 : XW'(int'(bx) - BALL_RADIUS);
        px[2] = int'(bx) + BALL_RADIUS > SCREEN_WIDTH - 1 ? XW'(SCREEN_WIDTH - 1) : XW'(int'(bx) + BALL_RADIUS);
        py[3] = int'(by) < BALL_RADIUS ? '0 : YW'(int'(by) - BALL_RADIUS);
        py[4] = int'(by) + BALL_RADIUS > SCREEN_HEIGHT - 1 ? YW'(SCREEN_HEIGHT - 1) : YW'(int'(by) + BALL_RADIUS);
        for (int k = 0; k < 5; k++)
            hit[k] = dx[SAFE_LATENCY-1] == px[k] && dy[SAFE_LATENCY-1] == py[k];
    end

`ifdef ROUND_JUDGE_GRACE_EN
    localparam int GW = $clog2(GRACE_FRAMES+1);
    logic [GW-1:0] grace_cnt;
    assign in_grace = grace_cnt < GW'(GRACE_FRAMES);
    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            grace_cnt <= '0;
        else if (i_round_start)
            grace_cnt <= '0;
        else if (eval && in_grace)
            grace_cnt <= grace_cnt + 1'b1;
    end
`else
    assign in_grace = GRACE_FRAMES < 0;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = i_round_start ? RUNNING :
                    state == RUNNING ? (i_pause ? PAUSED : lose || win_now ? DONE : RUNNING) :
                    state == PAUSED && !i_pause ? RUNNING : state;
    end

    // Loss is checked first so a frame that both exhausts the timer and hits the limit loses
    always_comb begin
        miss_any = !(&flags) && !in_grace;
        miss_nxt = !eval ? o_miss_cnt : !miss_any ? '0 :
                   o_miss_cnt == MW'(MISS_LIMIT) ? o_miss_cnt : o_miss_cnt + 1'b1;
        time_nxt = eval && o_time_left != '0 ? o_time_left - 1'b1 : o_time_left;
        lose     = eval && miss_nxt == MW'(MISS_LIMIT);
        win_now  = eval && !lose && time_nxt == '0;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            o_time_left   <= '0;
            o_miss_cnt    <= '0;
            o_is_win      <= 1'b0;
            o_round_ended <= 1'b0;
            first         <= 1'b0;
        end else if (i_round_start) begin
            o_time_left   <= TW'(ROUND_FRAMES);
            o_miss_cnt    <= '0;
            o_is_win      <= 1'b0;
            o_round_ended <= 1'b0;
            first         <= 1'b1;
        end else begin
            o_time_left   <= time_nxt;
            o_miss_cnt    <= miss_nxt;
            o_is_win      <= o_is_win || win_now;
            o_round_ended <= lose || win_now;
            if (fs_run)
                first <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            dx    <= '0;
            dy    <= '0;
            bx    <= '0;
            by    <= '0;
            flags <= '1;
        end else begin
            dx[0] <= i_x;
            dy[0] <= i_y;
            for (int i = 1; i < SAFE_LATENCY; i++) begin
                dx[i] <= dx[i-1];
                dy[i] <= dy[i-1];
            end
            if (i_frame_start) begin
                bx <= i_ball_x;
                by <= i_ball_y;
            end
            flags <= i_round_start || i_frame_start ? '1 :
                     run ? flags & ~(hit & {5{!i_is_safe}}) : flags;
        end
    end
endmodule
